// File: rtl/wb_async_mem_ctrl.sv
// Bridge from an asynchronous SRAM-style master to a Wishbone classic master.
// Each master access becomes one Wishbone cycle, and mem_wait_n stalls the pins until it ends.
module wb_async_mem_ctrl #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int SW          = DW / 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 256,
  parameter int RETRY_MAX   = 3
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          mem_cs_n,
  input  logic          mem_oe_n,
  input  logic          mem_we_n,
  input  logic [SW-1:0] mem_bls_n,
  input  logic [AW-1:0] mem_a,
  input  logic [DW-1:0] mem_d_i,
  output logic [DW-1:0] mem_d_o,
  output logic          mem_d_oe,
  output logic          mem_wait_n,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [SW-1:0] wb_sel_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  output logic          err_o,
  output logic [2:0]    err_code_o,
  input  logic          err_clr_i,
  output logic [2:0]    dbg_state
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(RETRY_MAX + 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_RETRY = 3'd3,
    ST_HOLD  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  state_e               state_q;
  logic [SYNC_STAGES-1:0] cs_sync_q, oe_sync_q, we_sync_q;
  logic                 is_rd_q;
  logic [AW-1:0]        adr_q;
  logic [SW-1:0]        sel_q;
  logic [DW-1:0]        dat_q;
  logic [DW-1:0]        rdata_q;
  logic [TW-1:0]        tmo_q;
  logic [RW-1:0]        retry_q;
  logic                 err_q;
  logic [2:0]           code_q;

  logic cs_s, oe_s, we_s;
  logic busy, abort, tmo_hit, retry_out, busy_fail;

  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign oe_s = oe_sync_q[SYNC_STAGES-1];
  assign we_s = we_sync_q[SYNC_STAGES-1];

  assign busy      = (state_q == ST_WR) || (state_q == ST_RD);
  assign abort     = cs_s || (is_rd_q ? oe_s : we_s);
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
  assign retry_out = (retry_q == RW'(RETRY_MAX));
  // Any busy-cycle outcome that lands in ERROR; reads then return all-ones.
  assign busy_fail = !wb_ack_i &&
                     (wb_err_i || (wb_rty_i ? retry_out : (abort || tmo_hit)));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cs_sync_q <= '1;
      oe_sync_q <= '1;
      we_sync_q <= '1;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], mem_cs_n};
      oe_sync_q <= {oe_sync_q[SYNC_STAGES-2:0], mem_oe_n};
      we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], mem_we_n};
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      is_rd_q <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
    end else begin
      // A new error entry below overrides this clear in the same cycle.
      if (err_clr_i) begin
        err_q  <= 1'b0;
        code_q <= 3'd0;
      end
      case (state_q)
        ST_IDLE: begin
          tmo_q   <= '0;
          retry_q <= '0;
          if (!cs_s && !oe_s && !we_s) begin
            state_q <= ST_ERROR;
            is_rd_q <= 1'b0;
            err_q   <= 1'b1;
            code_q  <= 3'd1;
          end else if (!cs_s && !we_s) begin
            state_q <= ST_WR;
            is_rd_q <= 1'b0;
            adr_q   <= mem_a;
            dat_q   <= mem_d_i;
            sel_q   <= ~mem_bls_n;
          end else if (!cs_s && !oe_s) begin
            state_q <= ST_RD;
            is_rd_q <= 1'b1;
            adr_q   <= mem_a;
            sel_q   <= ~mem_bls_n;
          end
        end
        ST_WR, ST_RD: begin
          if (busy_fail && is_rd_q) rdata_q <= '1;
          if (wb_ack_i) begin
            state_q <= ST_HOLD;
            if (is_rd_q) rdata_q <= wb_dat_i;
          end else if (wb_err_i) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
            code_q  <= 3'd2;
          end else if (wb_rty_i) begin
            if (retry_out) begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
              code_q  <= 3'd3;
            end else begin
              state_q <= ST_RETRY;
              retry_q <= retry_q + RW'(1);
            end
          end else if (abort) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
            code_q  <= 3'd4;
          end else if (tmo_hit) begin
            state_q <= ST_ERROR;
            err_q   <= 1'b1;
            code_q  <= 3'd5;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_RETRY: begin
          tmo_q   <= '0;
          state_q <= is_rd_q ? ST_RD : ST_WR;
        end
        ST_HOLD: begin
          if (abort) state_q <= ST_IDLE;
        end
        ST_ERROR: begin
          if (cs_s || (oe_s && we_s)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_cyc_o   = busy;
  assign wb_stb_o   = busy;
  assign wb_we_o    = (state_q == ST_WR);
  assign wb_sel_o   = sel_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign mem_d_o    = rdata_q;
  assign mem_wait_n = !(busy || (state_q == ST_RETRY));
  assign mem_d_oe   = is_rd_q && ((state_q == ST_HOLD) || (state_q == ST_ERROR)) &&
                      !cs_s && !oe_s;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_wb_async_mem_ctrl.sv
// Directed bench for wb_async_mem_ctrl: an access-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_wb_async_mem_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int SS = 2;
  localparam int TMO = 8;
  localparam int RMAX = 3;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_GAP  = 2;
  localparam int M_HOLD = 3;
  localparam int M_ERR  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs_n, oe_n, we_n;
  logic [SW-1:0] bls_n;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic [DW-1:0] mem_d_o;
  logic          mem_d_oe, mem_wait_n;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [SW-1:0] wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          ack, err, rty, err_clr;
  logic          err_o;
  logic [2:0]    err_code_o;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_async_mem_ctrl #(
    .DW(DW), .AW(AW), .SW(SW), .SYNC_STAGES(SS), .TIMEOUT(TMO), .RETRY_MAX(RMAX)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .mem_cs_n(cs_n), .mem_oe_n(oe_n), .mem_we_n(we_n), .mem_bls_n(bls_n),
    .mem_a(a), .mem_d_i(d), .mem_d_o(mem_d_o), .mem_d_oe(mem_d_oe),
    .mem_wait_n(mem_wait_n),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
    .err_o(err_o), .err_code_o(err_code_o), .err_clr_i(err_clr),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Access-level model: strobe delay lines, one record for the access in flight.
  logic [SS-1:0] m_cs_p, m_oe_p, m_we_p;
  int            m_ph, m_wait, m_tries, m_code_new;
  bit            m_rd, m_sc, m_so, m_sw, m_act_hi;
  logic [AW-1:0] m_adr;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_dat, m_rdata;
  bit            m_err;
  int            m_code;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cs_p = '1; m_oe_p = '1; m_we_p = '1;
      m_ph = M_IDLE; m_wait = 0; m_tries = 0; m_rd = 0;
      m_adr = '0; m_sel = '0; m_dat = '0; m_rdata = '0;
      m_err = 0; m_code = 0;
    end else begin
      m_sc = m_cs_p[SS-1];
      m_so = m_oe_p[SS-1];
      m_sw = m_we_p[SS-1];
      m_cs_p = {m_cs_p[SS-2:0], cs_n};
      m_oe_p = {m_oe_p[SS-2:0], oe_n};
      m_we_p = {m_we_p[SS-2:0], we_n};
      m_code_new = 0;
      m_act_hi = m_sc || (m_rd ? m_so : m_sw);
      if (m_ph == M_IDLE) begin
        m_wait = 0;
        m_tries = 0;
        if (!m_sc && !m_so && !m_sw) begin
          m_rd = 0;
          m_code_new = 1;
        end else if (!m_sc && (!m_sw || !m_so)) begin
          m_rd = m_sw;
          m_adr = a;
          m_sel = ~bls_n;
          if (!m_sw) m_dat = d;
          m_ph = M_BUSY;
        end
      end else if (m_ph == M_BUSY) begin
        if (ack) begin
          m_ph = M_HOLD;
          if (m_rd) m_rdata = wb_dat_i;
        end else if (err) m_code_new = 2;
        else if (rty) begin
          if (m_tries == RMAX) m_code_new = 3;
          else begin
            m_tries++;
            m_ph = M_GAP;
          end
        end else if (m_act_hi) m_code_new = 4;
        else if (m_wait == TMO - 1) m_code_new = 5;
        else m_wait++;
        if (m_code_new != 0 && m_rd) m_rdata = '1;
      end else if (m_ph == M_GAP) begin
        m_wait = 0;
        m_ph = M_BUSY;
      end else if (m_ph == M_HOLD) begin
        if (m_act_hi) m_ph = M_IDLE;
      end else begin
        if (m_sc || (m_so && m_sw)) m_ph = M_IDLE;
      end
      if (m_code_new != 0) begin
        m_ph = M_ERR;
        m_err = 1;
        m_code = m_code_new;
      end else if (err_clr) begin
        m_err = 0;
        m_code = 0;
      end
    end
  end

  // Per-cycle comparison plus run-length measurements used by the directed checks.
  int  cyc_run = 0, cyc_len = 0, cyc_rises = 0, wait_run = 0, wait_len = 0;
  bit  cyc_prev = 0, wait_prev = 1;
  logic [2:0] e_dbg;
  bit  e_busy;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      e_busy = (m_ph == M_BUSY);
      case (m_ph)
        M_BUSY:  e_dbg = m_rd ? 3'd2 : 3'd1;
        M_GAP:   e_dbg = 3'd3;
        M_HOLD:  e_dbg = 3'd4;
        M_ERR:   e_dbg = 3'd5;
        default: e_dbg = 3'd0;
      endcase
      chk("cyc", wb_cyc_o, e_busy);
      chk("stb", wb_stb_o, e_busy);
      chk("we", wb_we_o, e_busy && !m_rd);
      chk("sel", wb_sel_o, m_sel);
      chk("adr", wb_adr_o, m_adr);
      chk("dat_o", wb_dat_o, m_dat);
      chk("mem_d_o", mem_d_o, m_rdata);
      chk("wait_n", mem_wait_n, !(e_busy || m_ph == M_GAP));
      chk("d_oe", mem_d_oe, (m_ph == M_HOLD || m_ph == M_ERR) && m_rd &&
                            !m_cs_p[SS-1] && !m_oe_p[SS-1]);
      chk("err_o", err_o, m_err);
      chk("err_code", err_code_o, m_code);
      chk("dbg_state", dbg_state, e_dbg);
    end
    if (wb_cyc_o) begin
      if (!cyc_prev) cyc_rises++;
      cyc_run++;
    end else if (cyc_prev) begin
      cyc_len = cyc_run;
      cyc_run = 0;
    end
    if (!mem_wait_n) wait_run++;
    else if (!wait_prev) begin
      wait_len = wait_run;
      wait_run = 0;
    end
    cyc_prev = wb_cyc_o;
    wait_prev = mem_wait_n;
  end

  task automatic wait_cyc(input logic lvl, input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_cyc_o == lvl) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  task automatic start_acc(input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [SW-1:0] bl);
    @(negedge clk);
    cs_n = 0;
    oe_n = wr;
    we_n = !wr;
    a = addr;
    d = data;
    bls_n = bl;
  endtask

  task automatic release_pins(input int n);
    cs_n = 1; oe_n = 1; we_n = 1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  initial begin
    int rises0;
    bit found;
    int k;
    rst = 1; cs_n = 1; oe_n = 1; we_n = 1; bls_n = '1; a = '0; d = '0;
    wb_dat_i = '0; ack = 0; err = 0; rty = 0; err_clr = 0;
    #1;
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_wait", mem_wait_n, 1);
    chk("rst_state", dbg_state, 0);
    chk("rst_err", {err_o, err_code_o}, 0);
    chk("rst_data", {wb_adr_o, mem_d_o}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    // Write with ack in the third cycle.
    start_acc(1, 32'h40, 32'hDEADBEEF, 4'b1100);
    wait_cyc(1, "wr_start");
    chk("wr_sel", wb_sel_o, 4'b0011);
    chk("wr_adr", wb_adr_o, 32'h40);
    chk("wr_dat", wb_dat_o, 32'hDEADBEEF);
    chk("wr_we", wb_we_o, 1);
    repeat (2) @(negedge clk);
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("wr_cyc_len", cyc_len, 3);
    chk("wr_wait_len", wait_len, 3);
    chk("wr_err", err_o, 0);
    release_pins(4);

    // Read, ack in the first cycle, then oe_n release.
    wb_dat_i = 32'h12345678;
    start_acc(0, 32'h80, 32'h0, 4'b0000);
    wait_cyc(1, "rd_start");
    ack = 1;
    @(negedge clk);
    ack = 0;
    chk("rd_cyc_len", cyc_len, 1);
    chk("rd_data", mem_d_o, 32'h12345678);
    chk("rd_d_oe", mem_d_oe, 1);
    oe_n = 1;
    found = 0;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state == 3'd0) begin
        found = 1;
        k = i;
        break;
      end
    end
    chk("rd_idle_found", found, 1);
    chk("rd_idle_delay", k, SS + 1);
    release_pins(4);

    // Two retries then ack.
    rises0 = cyc_rises;
    start_acc(1, 32'h44, 32'hA5A5A5A5, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      wait_cyc(1, "rty_cyc");
      if (i < 2) rty = 1;
      else ack = 1;
      @(negedge clk);
      rty = 0;
      ack = 0;
    end
    chk("rty_rises", cyc_rises - rises0, 3);
    chk("rty_err", err_o, 0);
    chk("rty_state", dbg_state, 4);
    release_pins(4);

    // Retry budget exhausted on the fourth rty.
    start_acc(1, 32'h48, 32'h11112222, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1, "rtyx_cyc");
      rty = 1;
      @(negedge clk);
      rty = 0;
    end
    chk("rtyx_code", {err_o, err_code_o}, {1'b1, 3'd3});
    chk("rtyx_wait", mem_wait_n, 1);
    release_pins(3);
    pulse_clr();
    chk("rtyx_clr", err_o, 0);

    // Read timeout with no termination.
    start_acc(0, 32'h4C, 32'h0, 4'b0000);
    wait_cyc(1, "tmo_start");
    wait_cyc(0, "tmo_end");
    chk("tmo_cyc_len", cyc_len, 8);
    chk("tmo_code", {err_o, err_code_o}, {1'b1, 3'd5});
    chk("tmo_data", mem_d_o, 32'hFFFFFFFF);
    chk("tmo_d_oe", mem_d_oe, 1);
    release_pins(3);
    pulse_clr();
    chk("tmo_clr", {err_o, err_code_o}, 0);

    // Protocol violation: all strobes low together.
    rises0 = cyc_rises;
    @(negedge clk);
    cs_n = 0; oe_n = 0; we_n = 0;
    repeat (6) @(negedge clk);
    chk("proto_code", {err_o, err_code_o}, {1'b1, 3'd1});
    chk("proto_no_cyc", cyc_rises - rises0, 0);
    release_pins(4);

    // Abort: we_n raised mid-write.
    start_acc(1, 32'h50, 32'h33334444, 4'b1110);
    wait_cyc(1, "abort_start");
    we_n = 1;
    wait_cyc(0, "abort_end");
    chk("abort_cyc_len", cyc_len, 3);
    chk("abort_code", {err_o, err_code_o}, {1'b1, 3'd4});
    release_pins(4);
    pulse_clr();

    // ack and err together: ack wins.
    wb_dat_i = 32'hCAFEF00D;
    start_acc(0, 32'h54, 32'h0, 4'b0000);
    wait_cyc(1, "ackerr_start");
    ack = 1; err = 1;
    @(negedge clk);
    ack = 0; err = 0;
    chk("ackerr_state", dbg_state, 4);
    chk("ackerr_err", err_o, 0);
    chk("ackerr_data", mem_d_o, 32'hCAFEF00D);
    release_pins(4);

    // New err in the same cycle as err_clr_i.
    start_acc(1, 32'h58, 32'h55556666, 4'b0000);
    wait_cyc(1, "clrerr_start");
    err = 1; err_clr = 1;
    @(negedge clk);
    err = 0; err_clr = 0;
    chk("clrerr_code", {err_o, err_code_o}, {1'b1, 3'd2});
    chk("clrerr_state", dbg_state, 5);
    release_pins(4);

    // Asynchronous reset in the middle of a read.
    start_acc(0, 32'h5C, 32'h0, 4'b0000);
    wait_cyc(1, "rst_rd_start");
    #2;
    rst = 1;
    #1;
    chk("arst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    chk("arst_wait", mem_wait_n, 1);
    chk("arst_state", dbg_state, 0);
    chk("arst_err", {err_o, err_code_o}, 0);
    chk("arst_regs", {wb_sel_o, wb_adr_o}, 0);
    chk("arst_data", {wb_dat_o, mem_d_o}, 0);
    chk("arst_d_oe", mem_d_oe, 0);
    cs_n = 1; oe_n = 1; we_n = 1;
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_async_mem_ctrl.md
# wb_async_mem_ctrl

Parametrised asynchronous-memory-bus to Wishbone master bridge controller. External SRAM-style master (cs_n/oe_n/we_n/bls_n) drives the pins. The block synchronises the strobes, issues one Wishbone classic cycle per access, and holds the master with `mem_wait_n`. Adds byte lanes, read-data return, retry handling, timeout and sticky error reporting. Sits between the pin-level bridge and the system Wishbone interconnect.

## Interface
Parameters:
- `DW`, 32: data width; multiple of 8.
- `AW`, 32: address width.
- `SW`, DW/8: byte-lane count (derived).
- `SYNC_STAGES`, 2: synchroniser depth for `mem_cs_n`/`mem_oe_n`/`mem_we_n`; minimum 2.
- `TIMEOUT`, 256: cycles with cyc asserted and no ack/err/rty before abort; minimum 2.
- `RETRY_MAX`, 3: number of `wb_rty_i` tolerated per access; 0 means the first rty is an error.

Ports:
- `wb_clk_i` in 1: clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `mem_cs_n`, `mem_oe_n`, `mem_we_n` in 1 each: asynchronous strobes, active low.
- `mem_bls_n` in SW: byte-lane selects, active low.
- `mem_a` in AW: address.
- `mem_d_i` in DW: write data.
- `mem_d_o` out DW: read data.
- `mem_d_oe` out 1: pad output enable for read data.
- `mem_wait_n` out 1: low while the access is in flight.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each: Wishbone control.
- `wb_sel_o` out SW: byte selects.
- `wb_adr_o` out AW: address.
- `wb_dat_o` out DW: write data.
- `wb_dat_i` in DW: read data.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i` in 1 each: Wishbone terminations.
- `err_o` out 1: sticky error flag.
- `err_code_o` out 3: code of the last error.
- `err_clr_i` in 1: clears `err_o` and `err_code_o`.
- `dbg_state` out 3: binary state encoding.

## Operation
- States: IDLE=0, WR=1, RD=2, RETRY=3, HOLD=4, ERROR=5. Undefined encodings go to IDLE on the next edge.
- Strobes pass through SYNC_STAGES flops, which reset to 1. `mem_a`, `mem_d_i` and `mem_bls_n` are sampled raw on IDLE exit. The master must hold them stable while `mem_wait_n` is low.
- IDLE:
  - cs & oe & we all low (synchronised) → ERROR, code 1 (protocol).
  - cs & we low → WR. Latch `wb_adr_o`=mem_a, `wb_dat_o`=mem_d_i, `wb_sel_o`=~mem_bls_n.
  - cs & oe low → RD. Latch address and sel.
  - Clear the retry and timeout counters on either entry.
- WR/RD:
  - `wb_cyc_o`=`wb_stb_o`=1; `wb_we_o`=1 in WR only.
  - Termination priority: ack > err > rty > abort > timeout.
  - ack → HOLD. In RD, capture `wb_dat_i` into `mem_d_o`.
  - err → ERROR, code 2.
  - rty: if retry_cnt==RETRY_MAX → ERROR, code 3; else retry_cnt+1 → RETRY.
  - Abort (sync cs_n high, or the active strobe high) → ERROR, code 4.
  - timeout_cnt==TIMEOUT-1 → ERROR, code 5.
  - Otherwise timeout_cnt+1.
- RETRY: cyc/stb low for exactly one cycle. Clear timeout_cnt. Return to WR/RD per the latched direction.
- HOLD:
  - `mem_wait_n`=1.
  - `mem_d_oe`=1 when the access was a read and sync cs_n & oe_n are both low.
  - Exit to IDLE when sync cs_n is high or the active strobe is high.
- ERROR:
  - `mem_wait_n`=1.
  - For a read, `mem_d_o`={DW{1}} and `mem_d_oe` follows the same rule as HOLD.
  - Exit to IDLE when sync cs_n is high or both strobes are high.
- Errors:
  - Entering ERROR sets `err_o`=1 and `err_code_o`=code.
  - `err_clr_i` clears both.
  - A new error entry in the same cycle as `err_clr_i` wins.
- `mem_wait_n`=0 in WR, RD and RETRY; 1 otherwise.

## Timing
- Reset values: state IDLE; cyc/stb/we 0; sel, adr, dat_o, mem_d_o all 0; `mem_d_oe` 0; `mem_wait_n` 1; `err_o` 0; `err_code_o` 0.
- All outputs are registered or decoded from the state register. No combinational input→output path.
- Strobe pin fall → visible to the FSM after SYNC_STAGES edges. The next edge enters WR/RD, so cyc is high SYNC_STAGES+1 edges after the pin edge.
- `mem_wait_n` falls in the same cycle cyc rises. The master must treat wait as valid SYNC_STAGES+2 cycles after strobe assertion.
- ack sampled at edge E → cyc low, HOLD, `mem_d_o` valid and `mem_wait_n` high after E. Minimum access is 1 Wishbone cycle.
- Back-to-back accesses must pass through IDLE, at minimum 1 cycle after the release is seen.
- Reset mid-access drops cyc/stb immediately (asynchronous) and releases wait.

## Test plan
- Write: bls_n=4'b1100, a=0x40, d=0xDEADBEEF, ack after 3 cycles → one cyc of 3 cycles, we=1, sel=4'b0011, adr=0x40, dat_o=0xDEADBEEF; wait low for 3 cycles; err_o stays 0.
- Read: wb_dat_i=0x12345678, ack in first cycle → cyc lasts 1 cycle; mem_d_o=0x12345678; mem_d_oe high until oe_n rises; state IDLE SYNC_STAGES+1 cycles later.
- Retry: rty twice then ack, RETRY_MAX=3 → two 1-cycle cyc gaps, access completes, err_o=0. With RETRY_MAX=1, the second rty → err_code 3 and wait released.
- Timeout: TIMEOUT=8, no termination → cyc high exactly 8 cycles, err_code 5, read returns all-ones. err_clr_i then clears err_o.
- Protocol/abort: oe_n & we_n low together → ERROR, code 1, no cyc. Separately, raise we_n mid-WR → cyc drops, code 4.
- Simultaneous/reset: ack and err in the same cycle → HOLD, no error. err_clr_i coinciding with a new err → err_o stays 1 with code 2. wb_rst_i asserted mid-read → all outputs return to reset values without waiting for a clock edge.
